pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequences the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC: stall, flush, bubble insertion.
//  Detects load-use hazards, flushes on taken branches and freezes the pipe while data memory is not ready.
//  Sits beside the control unit; its outputs drive the enable and flush pins of each pipeline register.
// PARAMETERS
//  REG_ADDR_W   4    register-file address width
//  WAIT_MAX     15   MEM_WAIT cycles before mem_timeout is raised (1..2^WAIT_W-1)
//  WAIT_W       4    width of the wait counter
//  PERF_W       16   width of the performance counters (PIPE_PERF_CNT_EN only)
// PORTS
//  clk             in   1           clock, rising edge
//  reset           in   1           asynchronous, active-low reset (0 = reset)
//  id_rn, id_rm    in   REG_ADDR_W  source registers of the instruction in ID
//  id_use_rn/rm    in   1           ID instruction reads rn / rm
//  ex_rd           in   REG_ADDR_W  destination register of the instruction in EX
//  ex_mem_enable   in   1           EX instruction accesses memory
//  ex_mem_rw       in   1           0 = load, 1 = store
//  ex_reg_write    in   1           EX instruction writes the register file
//  ex_branch_taken in   1           taken branch resolved in EX
//  mem_access      in   1           MEM stage holds an active memory access
//  mem_ready       in   1           data memory completes the access this cycle
//  pc_enable       out  1           PC may update
//  if_id_enable    out  1           IF/ID captures
//  if_id_flush     out  1           IF/ID loads a NOP
//  id_ex_enable    out  1           ID/EX captures
//  id_ex_flush     out  1           ID/EX loads all-zero control (bubble)
//  ex_mem_enable   out  1           EX/MEM captures
//  mem_wb_flush    out  1           MEM/WB loads all-zero control
//  mem_timeout     out  1           sticky: WAIT_MAX exceeded
// BEHAVIOUR
//  While reset=0: state=RUN, wait_cnt=0, mem_timeout=0, counters=0; all *_enable=0 and all *_flush=1.
//  FSM states: RUN, MEM_WAIT. Outputs are combinational from the state and the current inputs (zero latency).
//  Priority per cycle: memory wait > branch flush > load-use stall.
//  RUN, mem_access=1 & mem_ready=0: go to MEM_WAIT. This cycle, all enables=0 and mem_wb_flush=1.
//  MEM_WAIT: all enables=0 and mem_wb_flush=1. wait_cnt increments each cycle.
//    mem_ready=1: all enables=1 and mem_wb_flush=0 in that cycle; next state RUN; wait_cnt cleared.
//    wait_cnt reaches WAIT_MAX: set mem_timeout (cleared only by reset); release the stall as if mem_ready=1.
//  Branch (RUN, no memory wait, ex_branch_taken=1): if_id_flush=1 and id_ex_flush=1, all enables=1.
//    The load-use check is ignored in that cycle.
//  Load-use hazard condition:
//    ex_mem_enable & ~ex_mem_rw & ex_reg_write & ((id_use_rn & id_rn==ex_rd) | (id_use_rm & id_rm==ex_rd)).
//  Load-use response: pc_enable=0, if_id_enable=0, id_ex_flush=1; ex_mem_enable=1. Exactly one bubble per hazard.
//  Branch held during MEM_WAIT: EX is frozen, so ex_branch_taken stays high. The flush applies in the release cycle.
//  Quiet cycle: all enables=1 and all flush=0.
//  Reset mid-wait: MEM_WAIT is abandoned at once and all state clears.
// CONFIGURATION
//  PIPE_PERF_CNT_EN defined: adds outputs stall_cycles, flush_events and load_use_events, each PERF_W bits.
//    Each counter saturates at all-ones and clears on reset.
//    stall_cycles counts every cycle with pc_enable=0. flush_events counts branch flushes.
//  PIPE_PERF_CNT_EN undefined: these ports and their logic are absent; the remaining behaviour is identical.
// STRUCTURE
//  Shared package: state encoding (RUN=1'b0, MEM_WAIT=1'b1) and the LOAD/STORE encoding of mem_rw.
//  One sub-module, pipe_perf_counter: a saturating PERF_W counter, instantiated 3x under PIPE_PERF_CNT_EN.
// TESTING
//  1 Reset low for 3 clocks, then high: all enables=0/flushes=1 during reset, then all enables=1/flushes=0.
//  2 Load hazard, ex_rd=3 (load), id_rn=3, id_use_rn=1:
//      one cycle pc_enable=0, if_id_enable=0, id_ex_flush=1.
//      Store with the same registers: no stall.
//  3 mem_access=1, mem_ready=0 for 4 cycles, then 1:
//      enables=0 and mem_wb_flush=1 for 4 cycles; all enables=1 in the 5th cycle; state back to RUN.
//  4 ex_branch_taken=1 together with a load-use match:
//      if_id_flush=1, id_ex_flush=1, pc_enable=1; no stall.
//  5 mem_ready held 0 for 20 cycles (WAIT_MAX=15): mem_timeout=1 after the 15th wait cycle, pipe released.
//      mem_timeout stays 1 until reset.
//  6 Assert reset in the 2nd MEM_WAIT cycle: outputs take reset values immediately; after release, state=RUN, wait_cnt=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// +--------------------------------------------------------------------------+
// | Module   : pipeline_hazard_ctrl_pkg                                      |
// | Purpose  : Shared types and constants for the pipeline hazard controller |
// |            (FSM state encoding, memory direction encoding, control word).|
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

package pipeline_hazard_ctrl_pkg;

  // Controller FSM state encoding
  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;

  // Encoding of ex_mem_rw
  localparam logic MEM_LOAD  = 1'b0;
  localparam logic MEM_STORE = 1'b1;

  // Control word driven onto the pipeline register pins
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_fl;
    logic id_ex_en;
    logic id_ex_fl;
    logic ex_mem_en;
    logic mem_wb_fl;
  } pipe_ctrl_t;

  // Reset: nothing captures, every flush asserted
  localparam pipe_ctrl_t CTRL_RESET  = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_fl: 1'b1,
                                        id_ex_en: 1'b0, id_ex_fl: 1'b1, ex_mem_en: 1'b0,
                                        mem_wb_fl: 1'b1};
  // Memory freeze: whole pipe holds, a bubble drains into WB
  localparam pipe_ctrl_t CTRL_FREEZE = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_fl: 1'b0,
                                        id_ex_en: 1'b0, id_ex_fl: 1'b0, ex_mem_en: 1'b0,
                                        mem_wb_fl: 1'b1};
  // Taken branch: kill the two younger instructions, keep moving
  localparam pipe_ctrl_t CTRL_FLUSH  = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_fl: 1'b1,
                                        id_ex_en: 1'b1, id_ex_fl: 1'b1, ex_mem_en: 1'b1,
                                        mem_wb_fl: 1'b0};
  // Load-use: hold PC and IF/ID, insert one bubble into ID/EX
  localparam pipe_ctrl_t CTRL_BUBBLE = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_fl: 1'b0,
                                        id_ex_en: 1'b1, id_ex_fl: 1'b1, ex_mem_en: 1'b1,
                                        mem_wb_fl: 1'b0};
  // Quiet: everything advances
  localparam pipe_ctrl_t CTRL_QUIET  = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_fl: 1'b0,
                                        id_ex_en: 1'b1, id_ex_fl: 1'b0, ex_mem_en: 1'b1,
                                        mem_wb_fl: 1'b0};

  // True when the EX instruction is a register-writing load
  function automatic logic ex_is_load(input logic mem_enable, input logic mem_rw,
                                      input logic reg_write);
    return mem_enable & (mem_rw == MEM_LOAD) & reg_write;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_perf_counter.sv
// +--------------------------------------------------------------------------+
// | Module   : pipe_perf_counter                                             |
// | Purpose  : Saturating event counter; clears on reset, sticks at all-ones.|
// |            Only built when PIPE_PERF_CNT_EN is defined.                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

`ifdef PIPE_PERF_CNT_EN
module pipe_perf_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Increment on event unless already saturated
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule
`endif

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module   : pipeline_hazard_ctrl                                          |
// | Purpose  : Stall / flush / bubble sequencing of IF/ID, ID/EX, EX/MEM,    |
// |            MEM/WB and the PC. Handles load-use hazards, taken branches   |
// |            and data-memory wait with a sticky timeout.                   |
// |            Optional macro PIPE_PERF_CNT_EN adds performance counters.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter int WAIT_MAX   = 15,
  parameter int WAIT_W     = 4
`ifdef PIPE_PERF_CNT_EN
  ,
  parameter int PERF_W     = 16
`endif
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic [REG_ADDR_W-1:0] id_rn_i,
  input  logic [REG_ADDR_W-1:0] id_rm_i,
  input  logic                  id_use_rn_i,
  input  logic                  id_use_rm_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_mem_enable_i,
  input  logic                  ex_mem_rw_i,
  input  logic                  ex_reg_write_i,
  input  logic                  ex_branch_taken_i,
  input  logic                  mem_access_i,
  input  logic                  mem_ready_i,
  output logic                  pc_enable_o,
  output logic                  if_id_enable_o,
  output logic                  if_id_flush_o,
  output logic                  id_ex_enable_o,
  output logic                  id_ex_flush_o,
  output logic                  ex_mem_enable_o,
  output logic                  mem_wb_flush_o,
  output logic                  mem_timeout_o
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]     stall_cycles_o,
  output logic [PERF_W-1:0]     flush_events_o,
  output logic [PERF_W-1:0]     load_use_events_o
`endif
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX);
  localparam logic [WAIT_W-1:0] WAIT_PRE  = WAIT_W'(WAIT_MAX - 1);

  logic [0:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;

  logic       rn_hit, rm_hit, load_use;
  logic       wait_done, rel_now, hold;
  logic       branch_flush, lu_stall;
  pipe_ctrl_t ctrl;

  assign rn_hit   = id_use_rn_i & (id_rn_i == ex_rd_i);
  assign rm_hit   = id_use_rm_i & (id_rm_i == ex_rd_i);
  assign load_use = ex_is_load(ex_mem_enable_i, ex_mem_rw_i, ex_reg_write_i) & (rn_hit | rm_hit);

  // The wait ends either on mem_ready or once the counter has reached the limit
  assign wait_done = (wait_cnt_q == WAIT_LAST);
  assign rel_now   = (state_q == ST_MEM_WAIT) & (mem_ready_i | wait_done);
  assign hold      = (state_q == ST_RUN) ? (mem_access_i & ~mem_ready_i) : ~rel_now;

  // The release cycle of a memory wait is treated as an ordinary running cycle:
  // a branch held in EX during the freeze flushes now, and a pending load-use
  // pair still receives its bubble.
  assign branch_flush = ~hold & ex_branch_taken_i;
  assign lu_stall     = ~hold & ~ex_branch_taken_i & load_use;

  // Pipeline control word: reset > memory freeze > branch flush > load-use bubble
  always_comb begin
    ctrl = CTRL_QUIET;
    if (!reset_ni) begin
      ctrl = CTRL_RESET;
    end else if (hold) begin
      ctrl = CTRL_FREEZE;
    end else if (branch_flush) begin
      ctrl = CTRL_FLUSH;
    end else if (lu_stall) begin
      ctrl = CTRL_BUBBLE;
    end
  end

  assign pc_enable_o     = ctrl.pc_en;
  assign if_id_enable_o  = ctrl.if_id_en;
  assign if_id_flush_o   = ctrl.if_id_fl;
  assign id_ex_enable_o  = ctrl.id_ex_en;
  assign id_ex_flush_o   = ctrl.id_ex_fl;
  assign ex_mem_enable_o = ctrl.ex_mem_en;
  assign mem_wb_flush_o  = ctrl.mem_wb_fl;
  assign mem_timeout_o   = timeout_q;

  // FSM next state, wait counter and sticky timeout. The timeout flag is set
  // at the end of the WAIT_MAX-th unanswered wait cycle so that it is already
  // visible in the cycle the stall is forcibly released.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    case (state_q)
      ST_RUN: begin
        if (mem_access_i && !mem_ready_i) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (rel_now) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
          if (wait_cnt_q == WAIT_PRE) begin
            timeout_d = 1'b1;
          end
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // State registers; reset abandons any wait immediately
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  pipe_perf_counter #(
    .WIDTH (PERF_W)
  ) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_ni  (reset_ni),
    .inc_i   (~ctrl.pc_en),
    .count_o (stall_cycles_o)
  );

  pipe_perf_counter #(
    .WIDTH (PERF_W)
  ) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_ni  (reset_ni),
    .inc_i   (branch_flush),
    .count_o (flush_events_o)
  );

  pipe_perf_counter #(
    .WIDTH (PERF_W)
  ) u_load_use_cnt (
    .clk_i   (clk_i),
    .rst_ni  (reset_ni),
    .inc_i   (lu_stall),
    .count_o (load_use_events_o)
  );
`endif

endmodule

`default_nettype wire
